// File: rtl/ctrl_pipe_decoder.sv
// Main-control decoder for the 5-stage MIPS pipeline, ID/EX/MEM/WB control regs.
// Optional jump support (j, jal) is enabled by defining CTRL_JUMP_EN.
module ctrl_pipe_decoder #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int REG_W   = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               id_valid_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic [REG_W-1:0]   id_rs_i,
    input  logic [REG_W-1:0]   id_rt_i,
    input  logic [REG_W-1:0]   ex_rt_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               hazard_o,
    output logic               ex_valid_o,
    output logic [ALUOP_W-1:0] ex_alu_op_o,
    output logic               ex_alusrc_o,
    output logic               ex_regdst_o,
    output logic               ex_illegal_o,
    output logic               mem_branch_o,
    output logic [1:0]         mem_br_type_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               wb_regwrite_o,
    output logic               wb_memtoreg_o
`ifdef CTRL_JUMP_EN
   ,output logic               id_jump_o,
    output logic               wb_link_o
`endif
);

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_BGEZ = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_BGTZ = OP_W'(6'b000111);
`ifdef CTRL_JUMP_EN
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b000011);
`endif

    typedef struct packed {
        logic               valid;
        logic [ALUOP_W-1:0] alu_op;
        logic               alusrc;
        logic               regdst;
        logic               illegal;
        logic               branch;
        logic [1:0]         br_type;
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic               memtoreg;
`ifdef CTRL_JUMP_EN
        logic               link;
`endif
    } ex_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       branch;
        logic [1:0] br_type;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
`ifdef CTRL_JUMP_EN
        logic       link;
`endif
    } mem_ctrl_t;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memtoreg;
`ifdef CTRL_JUMP_EN
        logic link;
`endif
    } wb_ctrl_t;

    ex_ctrl_t  dec;
    ex_ctrl_t  ex_q;
    mem_ctrl_t mem_q;
    mem_ctrl_t mem_d;
    wb_ctrl_t  wb_q;
    wb_ctrl_t  wb_d;
    logic      rt_used;
`ifdef CTRL_JUMP_EN
    logic      dec_jump;
`endif

    // Opcode decode, squashed to an all-zero bubble when ID is empty
    always_comb begin
        dec     = '0;
        rt_used = 1'b0;
`ifdef CTRL_JUMP_EN
        dec_jump = 1'b0;
`endif
        dec.valid = 1'b1;
        case (instr_op_i)
            OP_R: begin
                dec.regdst   = 1'b1;
                dec.regwrite = 1'b1;
                dec.alu_op   = ALUOP_W'(3'b100);
                rt_used      = 1'b1;
            end
            OP_ADDI: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_SLTI: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.alu_op   = ALUOP_W'(3'b010);
            end
            OP_LW: begin
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_SW: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                rt_used      = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BGEZ, OP_BGTZ: begin
                dec.branch = 1'b1;
                dec.alu_op = ALUOP_W'(3'b001);
                rt_used    = (instr_op_i == OP_BEQ) || (instr_op_i == OP_BNE);
                case (instr_op_i)
                    OP_BNE:  dec.br_type = 2'b01;
                    OP_BGEZ: dec.br_type = 2'b10;
                    OP_BGTZ: dec.br_type = 2'b11;
                    default: dec.br_type = 2'b00;
                endcase
            end
`ifdef CTRL_JUMP_EN
            OP_J: begin
                dec_jump = 1'b1;
            end
            OP_JAL: begin
                dec_jump     = 1'b1;
                dec.regwrite = 1'b1;
                dec.link     = 1'b1;
            end
`endif
            default: dec.illegal = 1'b1;
        endcase
        if (!id_valid_i) begin
            dec     = '0;
            rt_used = 1'b0;
`ifdef CTRL_JUMP_EN
            dec_jump = 1'b0;
`endif
        end
    end

    // Load-use: the load in EX writes a register the ID instruction reads
    assign hazard_o = !rst_i && id_valid_i && ex_q.valid && ex_q.memread &&
                      (ex_rt_i != '0) &&
                      ((ex_rt_i == id_rs_i) ||
                       (rt_used && (ex_rt_i == id_rt_i)));

    // Next-stage views of the EX and MEM control bundles
    always_comb begin
        mem_d          = '0;
        mem_d.valid    = ex_q.valid;
        mem_d.branch   = ex_q.branch;
        mem_d.br_type  = ex_q.br_type;
        mem_d.memread  = ex_q.memread;
        mem_d.memwrite = ex_q.memwrite;
        mem_d.regwrite = ex_q.regwrite;
        mem_d.memtoreg = ex_q.memtoreg;
`ifdef CTRL_JUMP_EN
        mem_d.link     = ex_q.link;
`endif
        wb_d           = '0;
        wb_d.valid     = mem_q.valid;
        wb_d.regwrite  = mem_q.regwrite;
        wb_d.memtoreg  = mem_q.memtoreg;
`ifdef CTRL_JUMP_EN
        wb_d.link      = mem_q.link;
`endif
    end

    // Stage registers: reset > flush > stall > load-use bubble > shift
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (flush_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= wb_d;
        end else if (!stall_i) begin
            ex_q  <= hazard_o ? '0 : dec;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_valid_o    = ex_q.valid;
    assign ex_alu_op_o   = ex_q.alu_op;
    assign ex_alusrc_o   = ex_q.alusrc;
    assign ex_regdst_o   = ex_q.regdst;
    assign ex_illegal_o  = ex_q.illegal;
    assign mem_branch_o  = mem_q.branch;
    assign mem_br_type_o = mem_q.br_type;
    assign mem_read_o    = mem_q.memread;
    assign mem_write_o   = mem_q.memwrite;
    assign wb_regwrite_o = wb_q.regwrite;
    assign wb_memtoreg_o = wb_q.memtoreg;
`ifdef CTRL_JUMP_EN
    assign id_jump_o     = dec_jump && !hazard_o;
    assign wb_link_o     = wb_q.link;
`endif

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Testbench for ctrl_pipe_decoder: directed scenarios then random traffic,
// checked against an opcode-level pipeline model.
module tb_ctrl_pipe_decoder;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       id_valid_i;
    logic [5:0] instr_op_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic [4:0] ex_rt_i;
    logic       stall_i;
    logic       flush_i;
    logic       hazard_o;
    logic       ex_valid_o;
    logic [2:0] ex_alu_op_o;
    logic       ex_alusrc_o;
    logic       ex_regdst_o;
    logic       ex_illegal_o;
    logic       mem_branch_o;
    logic [1:0] mem_br_type_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       wb_regwrite_o;
    logic       wb_memtoreg_o;
`ifdef CTRL_JUMP_EN
    logic       id_jump_o;
    logic       wb_link_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    ctrl_pipe_decoder dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
        .instr_op_i(instr_op_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .ex_rt_i(ex_rt_i), .stall_i(stall_i), .flush_i(flush_i),
        .hazard_o(hazard_o), .ex_valid_o(ex_valid_o),
        .ex_alu_op_o(ex_alu_op_o), .ex_alusrc_o(ex_alusrc_o),
        .ex_regdst_o(ex_regdst_o), .ex_illegal_o(ex_illegal_o),
        .mem_branch_o(mem_branch_o), .mem_br_type_o(mem_br_type_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .wb_regwrite_o(wb_regwrite_o), .wb_memtoreg_o(wb_memtoreg_o)
`ifdef CTRL_JUMP_EN
       ,.id_jump_o(id_jump_o), .wb_link_o(wb_link_o)
`endif
    );

    localparam bit [5:0] R = 6'd0, ADDI = 6'd8, SLTI = 6'd10, LW = 6'd35;
    localparam bit [5:0] SW = 6'd43, BEQ = 6'd4, BNE = 6'd5;
    localparam bit [5:0] BGEZ = 6'd1, BGTZ = 6'd7, J = 6'd2, JAL = 6'd3;
    localparam bit [5:0] BAD = 6'd63;

    typedef struct packed {
        bit [2:0] aluop;
        bit       alusrc, regdst, illegal, branch;
        bit [1:0] brt;
        bit       rd, wr, rw, m2r, link, jump, rt_used;
    } attr_t;

    typedef struct {
        bit       v;
        bit [5:0] op;
        bit [4:0] rt;
    } st_t;

    st_t ex_m, mem_m, wb_m;
    st_t empty = '{v: 1'b0, op: 6'd0, rt: 5'd0};

    // Control attributes of one opcode, straight from the decode table
    function automatic attr_t attrs(input bit [5:0] op);
        attr_t a = '0;
        case (op)
            R:    begin a.regdst = 1; a.rw = 1; a.aluop = 3'b100; a.rt_used = 1; end
            ADDI: begin a.alusrc = 1; a.rw = 1; end
            SLTI: begin a.alusrc = 1; a.rw = 1; a.aluop = 3'b010; end
            LW:   begin a.alusrc = 1; a.rd = 1; a.m2r = 1; a.rw = 1; end
            SW:   begin a.alusrc = 1; a.wr = 1; a.rt_used = 1; end
            BEQ:  begin a.branch = 1; a.aluop = 3'b001; a.brt = 2'b00; a.rt_used = 1; end
            BNE:  begin a.branch = 1; a.aluop = 3'b001; a.brt = 2'b01; a.rt_used = 1; end
            BGEZ: begin a.branch = 1; a.aluop = 3'b001; a.brt = 2'b10; end
            BGTZ: begin a.branch = 1; a.aluop = 3'b001; a.brt = 2'b11; end
`ifdef CTRL_JUMP_EN
            J:    begin a.jump = 1; end
            JAL:  begin a.jump = 1; a.rw = 1; a.link = 1; end
`endif
            default: a.illegal = 1;
        endcase
        return a;
    endfunction

    function automatic attr_t at(input st_t s);
        return s.v ? attrs(s.op) : attr_t'(0);
    endfunction

    task automatic chk(input string tag, input bit [7:0] obs, input bit [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive ID inputs, check every output, then advance model
    task automatic step(input bit r, input bit v, input bit [5:0] op,
                        input bit [4:0] rs, input bit [4:0] rt,
                        input bit st, input bit fl);
        attr_t ae, am, aw, ai;
        bit hz;
        rst_i = r; id_valid_i = v; instr_op_i = op;
        id_rs_i = rs; id_rt_i = rt; stall_i = st; flush_i = fl;
        ex_rt_i = ex_m.rt;
        #1;
        ae = at(ex_m); am = at(mem_m); aw = at(wb_m);
        ai = v ? attrs(op) : attr_t'(0);
        hz = !r && v && ex_m.v && ex_m.op == LW && ex_m.rt != 0 &&
             (ex_m.rt == rs || (ai.rt_used && ex_m.rt == rt));
        chk("hazard", 8'(hazard_o), 8'(hz));
        chk("ex_valid", 8'(ex_valid_o), 8'(ex_m.v));
        chk("ex_alu_op", 8'(ex_alu_op_o), 8'(ae.aluop));
        chk("ex_alusrc", 8'(ex_alusrc_o), 8'(ae.alusrc));
        chk("ex_regdst", 8'(ex_regdst_o), 8'(ae.regdst));
        chk("ex_illegal", 8'(ex_illegal_o), 8'(ae.illegal));
        chk("mem_branch", 8'(mem_branch_o), 8'(am.branch));
        chk("mem_br_type", 8'(mem_br_type_o), 8'(am.brt));
        chk("mem_read", 8'(mem_read_o), 8'(am.rd));
        chk("mem_write", 8'(mem_write_o), 8'(am.wr));
        chk("wb_regwrite", 8'(wb_regwrite_o), 8'(aw.rw));
        chk("wb_memtoreg", 8'(wb_memtoreg_o), 8'(aw.m2r));
`ifdef CTRL_JUMP_EN
        chk("id_jump", 8'(id_jump_o), 8'(ai.jump && !hz));
        chk("wb_link", 8'(wb_link_o), 8'(aw.link));
`endif
        @(posedge clk_i);
        if (r) begin
            ex_m = empty; mem_m = empty; wb_m = empty;
        end else if (fl) begin
            wb_m = mem_m; mem_m = empty; ex_m = empty;
        end else if (!st) begin
            wb_m = mem_m; mem_m = ex_m;
            ex_m = (v && !hz) ? '{v: 1'b1, op: op, rt: rt} : empty;
        end
        #1;
    endtask

    task automatic nop();
        step(0, 0, 6'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        bit [5:0] ops [12];
        ops = '{R, ADDI, SLTI, LW, SW, BEQ, BNE, BGEZ, BGTZ, J, JAL, BAD};
        ex_m = empty; mem_m = empty; wb_m = empty;
        rst_i = 1; id_valid_i = 0; instr_op_i = 0; id_rs_i = 0;
        id_rt_i = 0; ex_rt_i = 0; stall_i = 0; flush_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        // reset state, then a lone lw walking down the pipe
        step(1, 1, LW, 5'd1, 5'd2, 0, 0);
        step(0, 1, LW, 5'd1, 5'd2, 0, 0);
        repeat (4) nop();
        // load-use hazard and the rt=0 exemption
        step(0, 1, LW, 5'd1, 5'd8, 0, 0);
        step(0, 1, R, 5'd8, 5'd3, 0, 0);
        step(0, 1, R, 5'd8, 5'd3, 0, 0);
        step(0, 1, LW, 5'd1, 5'd0, 0, 0);
        step(0, 1, R, 5'd0, 5'd0, 0, 0);
        repeat (3) nop();
        // back-to-back branches
        step(0, 1, BEQ, 5'd1, 5'd2, 0, 0);
        step(0, 1, BNE, 5'd1, 5'd2, 0, 0);
        step(0, 1, BGEZ, 5'd1, 5'd2, 0, 0);
        step(0, 1, BGTZ, 5'd1, 5'd2, 0, 0);
        repeat (4) nop();
        // flush overrides stall while sw sits in EX
        step(0, 1, LW, 5'd1, 5'd4, 0, 0);
        step(0, 1, SW, 5'd2, 5'd5, 0, 0);
        step(0, 1, ADDI, 5'd3, 5'd6, 1, 1);
        repeat (3) nop();
        // illegal opcode, then a reset mid-stream
        step(0, 1, BAD, 5'd1, 5'd2, 0, 0);
        step(0, 1, ADDI, 5'd1, 5'd2, 0, 0);
        step(0, 1, LW, 5'd1, 5'd2, 0, 0);
        step(1, 1, SW, 5'd1, 5'd2, 0, 0);
        nop();
        // three-cycle stall with a lw in MEM
        step(0, 1, LW, 5'd1, 5'd2, 0, 0);
        nop();
        repeat (3) step(0, 0, 6'd0, 5'd0, 5'd0, 1, 0);
        repeat (3) nop();
        // jumps (illegal unless jump support is built in)
        step(0, 1, JAL, 5'd0, 5'd31, 0, 0);
        step(0, 1, J, 5'd0, 5'd0, 0, 0);
        repeat (4) nop();
        // random traffic
        for (int i = 0; i < 500; i++) begin
            bit [5:0] op;
            int k;
            k = $urandom_range(0, 12);
            op = (k == 12) ? 6'($urandom) : ops[k];
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 7) != 0,
                 op,
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
